// File: rtl/id_ex_if.sv
// Decode -> execute handshake bundle for the ID/EX pipeline register.
// The master drives the decoded instruction plus the EX-side ready/flush.
// The slave is the pipeline register itself.
interface id_ex_if #(
    parameter int XLEN = 32
);
    // Decode side
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rd1;
    logic [XLEN-1:0] id_rd2;
    logic [XLEN-1:0] id_immext;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic [13:0]     id_ctrl;

    // Execute side
    logic            ex_ready;
    logic            flush;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rd1;
    logic [XLEN-1:0] ex_rd2;
    logic [XLEN-1:0] ex_immext;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic [13:0]     ex_ctrl;

    modport master (
        output id_valid, id_pc, id_rd1, id_rd2, id_immext,
               id_rs1, id_rs2, id_rd, id_ctrl, ex_ready, flush,
        input  id_ready, ex_valid, ex_pc, ex_rd1, ex_rd2, ex_immext,
               ex_rs1, ex_rs2, ex_rd, ex_ctrl
    );

    modport slave (
        input  id_valid, id_pc, id_rd1, id_rd2, id_immext,
               id_rs1, id_rs2, id_rd, id_ctrl, ex_ready, flush,
        output id_ready, ex_valid, ex_pc, ex_rd1, ex_rd2, ex_immext,
               ex_rs1, ex_rs2, ex_rd, ex_ctrl
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch/jump flush
// and saturating bubble/flush counters for performance debug.
// id_ctrl layout: {ResultSrc[1:0], MemWrite, ALUSrc, RegWrite, Jump, Branch,
//                  ALUControl[3:0], 3'b0}
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    id_ex_if.slave           bus,
    output logic [CNT_W-1:0] bubble_count,
    output logic [CNT_W-1:0] flush_count
);

    // Control bundle bit positions used by the hazard check
    localparam int CTRL_RESULTSRC_HI = 13;
    localparam int CTRL_RESULTSRC_LO = 12;
    localparam int CTRL_REGWRITE     = 9;

    // One captured instruction
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] immext;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [13:0]     ctrl;
    } entry_t;

    // Mutually exclusive register-update actions, highest priority first
    typedef enum logic [2:0] {
        UPD_FLUSH,
        UPD_LOAD,
        UPD_BUBBLE,
        UPD_IDLE,
        UPD_HOLD
    } upd_t;

    entry_t           r_entry;
    logic             r_valid;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    entry_t           w_id_entry;
    logic             w_ex_is_load;
    logic             w_load_use;
    logic             w_advance;
    upd_t             w_upd;

    // Saturating increment: an all-ones counter stays put instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_id_entry = '{
        pc:     bus.id_pc,
        rd1:    bus.id_rd1,
        rd2:    bus.id_rd2,
        immext: bus.id_immext,
        rs1:    bus.id_rs1,
        rs2:    bus.id_rs2,
        rd:     bus.id_rd,
        ctrl:   bus.id_ctrl
    };

    // A held load that writes a real register (x0 never creates a dependency)
    assign w_ex_is_load = r_valid
                        && (r_entry.ctrl[CTRL_RESULTSRC_HI:CTRL_RESULTSRC_LO] == 2'b01)
                        && r_entry.ctrl[CTRL_REGWRITE]
                        && (r_entry.rd != 5'd0);

    // Both source fields are compared even when the instruction ignores rs2;
    // an occasional spurious bubble is cheaper than decoding operand usage here.
    assign w_load_use = bus.id_valid && w_ex_is_load
                      && ((bus.id_rs1 == r_entry.rd) || (bus.id_rs2 == r_entry.rd));

    assign w_advance   = !r_valid || bus.ex_ready;
    assign bus.id_ready = w_advance && !w_load_use && !bus.flush;

    // Pick the single action the register takes at the next edge
    always_comb begin
        // NOTE: default assigned first so every path drives w_upd and no latch is inferred.
        w_upd = UPD_HOLD;
        if (bus.flush) begin
            w_upd = UPD_FLUSH;
        end else if (w_advance) begin
            if (bus.id_valid && !w_load_use) begin
                w_upd = UPD_LOAD;
            end else if (w_load_use) begin
                w_upd = UPD_BUBBLE;
            end else begin
                w_upd = UPD_IDLE;
            end
        end
    end

    // Pipeline entry: load, clear to a bubble, or hold while EX is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_entry <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            unique case (w_upd)
                UPD_LOAD: begin
                    r_valid <= 1'b1;
                    r_entry <= w_id_entry;
                end
                UPD_FLUSH, UPD_BUBBLE, UPD_IDLE: begin
                    // Clearing the whole entry zeroes RegWrite/MemWrite/Jump/Branch
                    r_valid <= 1'b0;
                    r_entry <= '0;
                end
                default: begin
                    // UPD_HOLD: EX has not consumed the entry; keep everything
                end
            endcase
        end
    end

    // Performance counters: bubbles only when not overridden by a flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_upd == UPD_BUBBLE) begin
                r_bubble_cnt <= sat_inc(r_bubble_cnt);
            end
            if (w_upd == UPD_FLUSH) begin
                r_flush_cnt <= sat_inc(r_flush_cnt);
            end
        end
    end

    assign bus.ex_valid  = r_valid;
    assign bus.ex_pc     = r_entry.pc;
    assign bus.ex_rd1    = r_entry.rd1;
    assign bus.ex_rd2    = r_entry.rd2;
    assign bus.ex_immext = r_entry.immext;
    assign bus.ex_rs1    = r_entry.rs1;
    assign bus.ex_rs2    = r_entry.rs2;
    assign bus.ex_rd     = r_entry.rd;
    assign bus.ex_ctrl   = r_entry.ctrl;
    assign bubble_count  = r_bubble_cnt;
    assign flush_count   = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by a random phase, checked
// against a cycle-level reference model of the stage's update rules. A second
// instance with 2-bit counters shares the same stimulus to exercise saturation.
module tb_id_ex_stage;

    localparam int XLEN = 32;

    localparam logic [13:0] C_ADD = {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 3'b000};
    localparam logic [13:0] C_SUB = {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 3'b000};
    localparam logic [13:0] C_LW  = {2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 3'b000};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_ex_if #(.XLEN(XLEN)) bus_a ();
    id_ex_if #(.XLEN(XLEN)) bus_b ();

    logic [15:0] bub_a, fl_a;
    logic [1:0]  bub_b, fl_b;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a),
        .bubble_count(bub_a), .flush_count(fl_a)
    );

    id_ex_stage #(.XLEN(XLEN), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b),
        .bubble_count(bub_b), .flush_count(fl_b)
    );

    assign bus_b.id_valid  = bus_a.id_valid;
    assign bus_b.id_pc     = bus_a.id_pc;
    assign bus_b.id_rd1    = bus_a.id_rd1;
    assign bus_b.id_rd2    = bus_a.id_rd2;
    assign bus_b.id_immext = bus_a.id_immext;
    assign bus_b.id_rs1    = bus_a.id_rs1;
    assign bus_b.id_rs2    = bus_a.id_rs2;
    assign bus_b.id_rd     = bus_a.id_rd;
    assign bus_b.id_ctrl   = bus_a.id_ctrl;
    assign bus_b.ex_ready  = bus_a.ex_ready;
    assign bus_b.flush     = bus_a.flush;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [XLEN-1:0] pc, rd1, rd2, immext;
        logic [4:0]      rs1, rs2, rd;
        logic [13:0]     ctrl;
    } ent_t;

    ent_t        m_ent;
    bit          m_valid;
    int unsigned m_bub, m_fl;
    int          n_cmp  = 0;
    int          n_fail = 0;

    function automatic void m_reset();
        m_valid = 1'b0;
        m_ent   = '0;
        m_bub   = 0;
        m_fl    = 0;
    endfunction

    function automatic ent_t cur_id();
        return '{pc: bus_a.id_pc, rd1: bus_a.id_rd1, rd2: bus_a.id_rd2,
                 immext: bus_a.id_immext, rs1: bus_a.id_rs1, rs2: bus_a.id_rs2,
                 rd: bus_a.id_rd, ctrl: bus_a.id_ctrl};
    endfunction

    function automatic bit m_load_use();
        bit is_load;
        is_load = m_valid && (m_ent.ctrl[13:12] == 2'b01) && m_ent.ctrl[9] && (m_ent.rd != 5'd0);
        return bus_a.id_valid && is_load && (bus_a.id_rs1 == m_ent.rd || bus_a.id_rs2 == m_ent.rd);
    endfunction

    function automatic bit m_ready();
        return (!m_valid || bus_a.ex_ready) && !m_load_use() && !bus_a.flush;
    endfunction

    function automatic void m_step();
        bit adv, lu;
        lu  = m_load_use();
        adv = !m_valid || bus_a.ex_ready;
        if (bus_a.flush) begin
            m_valid = 1'b0; m_ent = '0; m_fl++;
        end else if (adv && bus_a.id_valid && !lu) begin
            m_valid = 1'b1; m_ent = cur_id();
        end else if (adv) begin
            if (lu) m_bub++;
            m_valid = 1'b0; m_ent = '0;
        end
    endfunction

    function automatic logic [255:0] sat(input int unsigned v, input int unsigned mx);
        return 256'((v > mx) ? mx : v);
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"},  256'(bus_a.ex_valid), 256'(m_valid));
        check({tag, ".entry"},  256'({bus_a.ex_pc, bus_a.ex_rd1, bus_a.ex_rd2, bus_a.ex_immext,
                                      bus_a.ex_rs1, bus_a.ex_rs2, bus_a.ex_rd, bus_a.ex_ctrl}),
                                256'(m_ent));
        check({tag, ".bub16"},  256'(bub_a), sat(m_bub, 65535));
        check({tag, ".fl16"},   256'(fl_a),  sat(m_fl, 65535));
        check({tag, ".valid2"}, 256'(bus_b.ex_valid), 256'(m_valid));
        check({tag, ".bub2"},   256'(bub_b), sat(m_bub, 3));
        check({tag, ".fl2"},    256'(fl_b),  sat(m_fl, 3));
    endtask

    // Drive one decode slot; called just after a rising edge
    task automatic drive(input bit v, input logic [31:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [13:0] ctrl);
        bus_a.id_valid  = v;
        bus_a.id_pc     = pc;
        bus_a.id_rd1    = $urandom;
        bus_a.id_rd2    = $urandom;
        bus_a.id_immext = $urandom;
        bus_a.id_rs1    = rs1;
        bus_a.id_rs2    = rs2;
        bus_a.id_rd     = rd;
        bus_a.id_ctrl   = ctrl;
        #1;
    endtask

    // One clock: check id_ready mid-cycle, advance the model, check registers after the edge
    task automatic tick(input string tag);
        @(negedge clk);
        check({tag, ".id_ready"},  256'(bus_a.id_ready), 256'(m_ready()));
        check({tag, ".id_ready2"}, 256'(bus_b.id_ready), 256'(m_ready()));
        m_step();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    function automatic logic [13:0] rnd_ctrl();
        logic [13:0] c;
        c = 14'($urandom);
        c[2:0] = 3'b000;
        if ($urandom_range(1) == 1) c[13:12] = 2'b01;
        return c;
    endfunction

    initial begin
        rst_n          = 1'b0;
        bus_a.ex_ready = 1'b0;
        bus_a.flush    = 1'b0;
        bus_a.id_valid = 1'b0;
        bus_a.id_pc    = '0; bus_a.id_rd1 = '0; bus_a.id_rd2 = '0; bus_a.id_immext = '0;
        bus_a.id_rs1   = '0; bus_a.id_rs2 = '0; bus_a.id_rd = '0; bus_a.id_ctrl = '0;
        m_reset();
        #1;
        check_outputs("reset");
        check("reset.id_ready", 256'(bus_a.id_ready), 256'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: back-to-back ADD, SUB
        bus_a.ex_ready = 1'b1;
        drive(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, C_ADD);
        check("t1.add_ready", 256'(bus_a.id_ready), 256'(1));
        tick("t1.add");
        check("t1.add_pc", 256'(bus_a.ex_pc), 256'(32'h100));
        drive(1'b1, 32'h104, 5'd3, 5'd4, 5'd5, C_SUB);
        check("t1.sub_ready", 256'(bus_a.id_ready), 256'(1));
        tick("t1.sub");
        check("t1.sub_pc", 256'(bus_a.ex_pc), 256'(32'h104));
        check("t1.sub_ctrl", 256'(bus_a.ex_ctrl), 256'(C_SUB));

        // 2: load-use on rs1 costs one bubble
        drive(1'b1, 32'h200, 5'd1, 5'd2, 5'd5, C_LW);
        tick("t2.lw");
        drive(1'b1, 32'h204, 5'd5, 5'd6, 5'd7, C_ADD);
        check("t2.stall", 256'(bus_a.id_ready), 256'(0));
        tick("t2.bubble");
        check("t2.bub_valid", 256'(bus_a.ex_valid), 256'(0));
        check("t2.bub_ctrl", 256'(bus_a.ex_ctrl), 256'(0));
        check("t2.bub_cnt", 256'(bub_a), 256'(1));
        check("t2.retry_ready", 256'(bus_a.id_ready), 256'(1));
        tick("t2.accept");
        check("t2.accept_pc", 256'(bus_a.ex_pc), 256'(32'h204));

        // 3: load to x0 never stalls
        drive(1'b1, 32'h300, 5'd1, 5'd2, 5'd0, C_LW);
        tick("t3.lw_x0");
        drive(1'b1, 32'h304, 5'd0, 5'd0, 5'd8, C_ADD);
        check("t3.ready", 256'(bus_a.id_ready), 256'(1));
        tick("t3.add");
        check("t3.bub_cnt", 256'(bub_a), 256'(1));
        check("t3.add_pc", 256'(bus_a.ex_pc), 256'(32'h304));

        // 4: flush wins over load-use; no bubble counted
        drive(1'b1, 32'h400, 5'd1, 5'd2, 5'd8, C_LW);
        tick("t4.lw");
        bus_a.flush = 1'b1;
        drive(1'b1, 32'h404, 5'd8, 5'd0, 5'd9, C_ADD);
        check("t4.ready", 256'(bus_a.id_ready), 256'(0));
        tick("t4.flush");
        check("t4.valid", 256'(bus_a.ex_valid), 256'(0));
        check("t4.fl_cnt", 256'(fl_a), 256'(1));
        check("t4.bub_cnt", 256'(bub_a), 256'(1));
        bus_a.flush = 1'b0;

        // 5: EX stall holds the entry for three cycles
        drive(1'b1, 32'h500, 5'd1, 5'd2, 5'd3, C_ADD);
        tick("t5.add");
        bus_a.ex_ready = 1'b0;
        drive(1'b1, 32'h504, 5'd1, 5'd2, 5'd4, C_SUB);
        for (int i = 0; i < 3; i++) begin
            check("t5.stall_ready", 256'(bus_a.id_ready), 256'(0));
            tick("t5.hold");
            check("t5.hold_pc", 256'(bus_a.ex_pc), 256'(32'h500));
            check("t5.hold_valid", 256'(bus_a.ex_valid), 256'(1));
        end
        bus_a.ex_ready = 1'b1;
        #1;
        check("t5.release_ready", 256'(bus_a.id_ready), 256'(1));
        tick("t5.release");
        check("t5.release_pc", 256'(bus_a.ex_pc), 256'(32'h504));

        // Random phase: small register indices so hazards are frequent
        for (int i = 0; i < 400; i++) begin
            bus_a.ex_ready = ($urandom_range(9) < 7);
            bus_a.flush    = ($urandom_range(15) == 0);
            drive($urandom_range(9) < 8, $urandom, 5'($urandom_range(7)),
                  5'($urandom_range(7)), 5'($urandom_range(7)), rnd_ctrl());
            tick("rand");
        end

        // 6: five forced bubbles, then an asynchronous reset mid-cycle
        bus_a.flush    = 1'b0;
        bus_a.ex_ready = 1'b1;
        drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 14'd0);
        tick("t6.drain");
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h700 + 32'(i * 8), 5'd1, 5'd2, 5'd9, C_LW);
            tick("t6.lw");
            drive(1'b1, 32'h704 + 32'(i * 8), 5'd1, 5'd9, 5'd10, C_ADD);
            check("t6.stall", 256'(bus_a.id_ready), 256'(0));
            tick("t6.bubble");
            check("t6.bub_valid", 256'(bus_a.ex_valid), 256'(0));
        end
        check("t6.sat2", 256'(bub_b), 256'(2'd3));
        drive(1'b1, 32'h600, 5'd1, 5'd2, 5'd3, C_ADD);
        tick("t6.pre_reset");
        check("t6.pre_reset_valid", 256'(bus_a.ex_valid), 256'(1));
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        check_outputs("t6.async_reset");
        check("t6.reset_bub2", 256'(bub_b), 256'(0));
        check("t6.reset_ready", 256'(bus_a.id_ready), 256'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 32'h800, 5'd1, 5'd2, 5'd3, C_ADD);
        tick("t6.after_reset");
        check("t6.after_pc", 256'(bus_a.ex_pc), 256'(32'h800));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
